// File: rtl/sfx_event_sequencer_pkg.sv
// Shared constants for the sound-effect sequencer: event indices, note dividers and FSM states.
// Note dividers assume a 100 MHz clock (divider = f_clk / f_note).
package sfx_event_sequencer_pkg;

    localparam int EVT_JUMP  = 0;
    localparam int EVT_SCORE = 1;
    localparam int EVT_HIT   = 2;
    localparam int EVT_OVER  = 3;

    localparam int NOTE_REST = 0;
    localparam int NOTE_C4   = 382219;
    localparam int NOTE_D4   = 340530;
    localparam int NOTE_E4   = 303370;
    localparam int NOTE_F4   = 286344;
    localparam int NOTE_G4   = 255102;
    localparam int NOTE_A4   = 227273;
    localparam int NOTE_B4   = 202478;
    localparam int NOTE_C5   = 191113;
    localparam int NOTE_D5   = 170265;
    localparam int NOTE_E5   = 151685;
    localparam int NOTE_F5   = 143172;
    localparam int NOTE_G5   = 127551;
    localparam int NOTE_A5   = 113636;
    localparam int NOTE_B5   = 101239;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } sfx_state_t;

    // Index widths must stay at least one bit even for degenerate parameter choices.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/sfx_event_sequencer_if.sv
// Control/status bundle between the game logic and the sound-effect sequencer.
interface sfx_event_sequencer_if #(
    parameter int N_EVT   = 4,
    parameter int DIV_W   = 22,
    parameter int VOL_MAX = 5
);
    import sfx_event_sequencer_pkg::*;

    localparam int EVT_W = clog2_min1(N_EVT);

    logic [N_EVT-1:0]   evt_trig;
    logic               mute;
    logic               vol_up;
    logic               vol_down;
    logic [DIV_W-1:0]   note_div;
    logic               playing;
    logic [EVT_W-1:0]   cur_evt;
    logic               sfx_done;
    logic [2:0]         vol;
    logic [VOL_MAX-1:0] led_vol;

    modport master (
        output evt_trig, mute, vol_up, vol_down,
        input  note_div, playing, cur_evt, sfx_done, vol, led_vol
    );

    modport slave (
        input  evt_trig, mute, vol_up, vol_down,
        output note_div, playing, cur_evt, sfx_done, vol, led_vol
    );

endinterface

// File: rtl/sfx_event_sequencer_rom.sv
// Combinational note table: (effect index, beat index) -> note divider; beats past 8 are rests.
module sfx_event_sequencer_rom
    import sfx_event_sequencer_pkg::*;
#(
    parameter int N_EVT   = 4,
    parameter int SEQ_LEN = 8,
    parameter int DIV_W   = 22
) (
    input  logic [clog2_min1(N_EVT)-1:0]   i_evt,
    input  logic [clog2_min1(SEQ_LEN)-1:0] i_beat,
    output logic [DIV_W-1:0]               o_div
);

    localparam int SEQ_JUMP  [8] = '{NOTE_C4, NOTE_E4, NOTE_G4, NOTE_C5,
                                     NOTE_E5, NOTE_G5, NOTE_C5, NOTE_REST};
    localparam int SEQ_SCORE [8] = '{NOTE_E5, NOTE_G5, NOTE_REST, NOTE_C5,
                                     NOTE_E5, NOTE_G5, NOTE_A5, NOTE_B5};
    localparam int SEQ_HIT   [8] = '{NOTE_G4, NOTE_F4, NOTE_E4, NOTE_D4,
                                     NOTE_C4, NOTE_REST, NOTE_C4, NOTE_REST};
    localparam int SEQ_OVER  [8] = '{NOTE_C5, NOTE_B4, NOTE_A4, NOTE_G4,
                                     NOTE_F4, NOTE_E4, NOTE_D4, NOTE_C4};

    logic [2:0] w_beat3;
    logic       w_beat_ok;
    int         w_note;

    assign w_beat3   = 3'(i_beat);
    assign w_beat_ok = (int'(i_beat) < 8);

    always_comb begin
        w_note = NOTE_REST;
        if (w_beat_ok) begin
            case (int'(i_evt))
                EVT_JUMP:  w_note = SEQ_JUMP[w_beat3];
                EVT_SCORE: w_note = SEQ_SCORE[w_beat3];
                EVT_HIT:   w_note = SEQ_HIT[w_beat3];
                EVT_OVER:  w_note = SEQ_OVER[w_beat3];
                default:   w_note = NOTE_REST;
            endcase
        end
    end

    assign o_div = DIV_W'(w_note);

endmodule

// File: rtl/sfx_event_sequencer.sv
// Sound-effect sequencer: edge-detected prioritised triggers, fixed-length note sequences,
// registered note divider with mute, and a saturating volume level with thermometer LEDs.
module sfx_event_sequencer
    import sfx_event_sequencer_pkg::*;
#(
    parameter int N_EVT    = 4,
    parameter int SEQ_LEN  = 8,
    parameter int BEAT_DIV = 4194304,
    parameter int DIV_W    = 22,
    parameter int VOL_MAX  = 5,
    parameter int VOL_RST  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sfx_event_sequencer_if.slave io_sfx
);

    localparam int EVT_W  = clog2_min1(N_EVT);
    localparam int BEAT_W = clog2_min1(SEQ_LEN);
    localparam int CNT_W  = clog2_min1(BEAT_DIV);
    localparam logic [VOL_MAX-1:0] LED_RST = VOL_MAX'((1 << VOL_RST) - 1);

    sfx_state_t          r_state;
    logic [N_EVT-1:0]    r_evt_prev;
    logic [EVT_W-1:0]    r_cur_evt;
    logic [BEAT_W-1:0]   r_beat_idx;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic                r_sfx_done;
    logic [DIV_W-1:0]    r_note_div;
    logic [2:0]          r_vol;
    logic [VOL_MAX-1:0]  r_led_vol;

    sfx_state_t          w_state_next;
    logic [N_EVT-1:0]    w_evt_rise;
    logic                w_any_rise;
    logic [EVT_W-1:0]    w_winner;
    logic [EVT_W-1:0]    w_cur_evt_next;
    logic [BEAT_W-1:0]   w_beat_idx_next;
    logic [CNT_W-1:0]    w_beat_cnt_next;
    logic                w_sfx_done_next;
    logic [DIV_W-1:0]    w_rom_div;
    logic [2:0]          w_vol_next;
    logic [VOL_MAX-1:0]  w_led_next;

    assign w_evt_rise = io_sfx.evt_trig & ~r_evt_prev;
    assign w_any_rise = |w_evt_rise;

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        w_winner = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (w_evt_rise[i]) begin
                w_winner = EVT_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_evt_prev <= '1;
            r_cur_evt  <= '0;
            r_beat_idx <= '0;
            r_beat_cnt <= '0;
            r_sfx_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_evt_prev <= io_sfx.evt_trig;
            r_cur_evt  <= w_cur_evt_next;
            r_beat_idx <= w_beat_idx_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_sfx_done <= w_sfx_done_next;
        end
    end

    // A new or equal-priority trigger always wins over beat advance, including on the final beat.
    always_comb begin
        w_state_next    = r_state;
        w_cur_evt_next  = r_cur_evt;
        w_beat_idx_next = r_beat_idx;
        w_beat_cnt_next = r_beat_cnt;
        w_sfx_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_rise) begin
                    w_state_next    = ST_PLAY;
                    w_cur_evt_next  = w_winner;
                    w_beat_idx_next = '0;
                    w_beat_cnt_next = '0;
                end
            end
            ST_PLAY: begin
                if (w_any_rise && (w_winner >= r_cur_evt)) begin
                    w_cur_evt_next  = w_winner;
                    w_beat_idx_next = '0;
                    w_beat_cnt_next = '0;
                end else if (r_beat_cnt == CNT_W'(BEAT_DIV - 1)) begin
                    w_beat_cnt_next = '0;
                    if (r_beat_idx == BEAT_W'(SEQ_LEN - 1)) begin
                        w_state_next    = ST_IDLE;
                        w_beat_idx_next = '0;
                        w_sfx_done_next = 1'b1;
                    end else begin
                        w_beat_idx_next = r_beat_idx + 1'b1;
                    end
                end else begin
                    w_beat_cnt_next = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    sfx_event_sequencer_rom #(
        .N_EVT   (N_EVT),
        .SEQ_LEN (SEQ_LEN),
        .DIV_W   (DIV_W)
    ) u_rom (
        .i_evt  (r_cur_evt),
        .i_beat (r_beat_idx),
        .o_div  (w_rom_div)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_note_div <= '0;
        end else begin
            r_note_div <= ((r_state != ST_PLAY) || io_sfx.mute) ? '0 : w_rom_div;
        end
    end

    // Simultaneous up/down cancel; both ends saturate.
    always_comb begin
        w_vol_next = r_vol;
        if (io_sfx.vol_up && !io_sfx.vol_down && (r_vol < 3'(VOL_MAX))) begin
            w_vol_next = r_vol + 3'd1;
        end else if (io_sfx.vol_down && !io_sfx.vol_up && (r_vol != 3'd0)) begin
            w_vol_next = r_vol - 3'd1;
        end
    end

    always_comb begin
        w_led_next = '0;
        for (int i = 0; i < VOL_MAX; i++) begin
            w_led_next[i] = (int'(w_vol_next) > i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vol     <= 3'(VOL_RST);
            r_led_vol <= LED_RST;
        end else begin
            r_vol     <= w_vol_next;
            r_led_vol <= w_led_next;
        end
    end

    assign io_sfx.note_div = r_note_div;
    assign io_sfx.playing  = (r_state == ST_PLAY);
    assign io_sfx.cur_evt  = r_cur_evt;
    assign io_sfx.sfx_done = r_sfx_done;
    assign io_sfx.vol      = r_vol;
    assign io_sfx.led_vol  = r_led_vol;

endmodule

// File: tb/tb_sfx_event_sequencer.sv
// Bench for sfx_event_sequencer: directed scenarios plus random stimulus against an
// elapsed-time reference model of the effect player and volume level.
module tb_sfx_event_sequencer;

    localparam int N_EVT    = 4;
    localparam int SEQ_LEN  = 4;
    localparam int BEAT_DIV = 4;
    localparam int DIV_W    = 22;
    localparam int VOL_MAX  = 5;
    localparam int VOL_RST  = 3;
    localparam int SEQ_CYC  = SEQ_LEN * BEAT_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sfx_event_sequencer_if #(.N_EVT(N_EVT), .DIV_W(DIV_W), .VOL_MAX(VOL_MAX)) sfx_if ();

    sfx_event_sequencer #(
        .N_EVT    (N_EVT),
        .SEQ_LEN  (SEQ_LEN),
        .BEAT_DIV (BEAT_DIV),
        .DIV_W    (DIV_W),
        .VOL_MAX  (VOL_MAX),
        .VOL_RST  (VOL_RST)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_sfx  (sfx_if)
    );

    // First four notes of each effect: jump, score, hit, game-over.
    int note_tbl [4][4] = '{
        '{382219, 303370, 255102, 191113},
        '{151685, 127551, 0,      191113},
        '{255102, 286344, 303370, 340530},
        '{191113, 202478, 227273, 255102}
    };

    // Reference model: an effect is "active" for SEQ_CYC cycles from its start;
    // the beat being played is simply elapsed / BEAT_DIV.
    bit         m_active  = 1'b0;
    logic [1:0] m_evt     = 2'd0;
    int         m_elapsed = 0;
    logic [3:0] m_prev    = 4'hF;
    logic [3:0] m_rise;
    int         m_winner;
    logic [1:0] m_beat;
    int         exp_note  = 0;
    bit         exp_done  = 1'b0;
    int         exp_vol   = VOL_RST;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active  = 1'b0;
                m_evt     = 2'd0;
                m_elapsed = 0;
                m_prev    = 4'hF;
                exp_note  = 0;
                exp_done  = 1'b0;
                exp_vol   = VOL_RST;
            end else begin
                m_beat   = 2'(m_elapsed / BEAT_DIV);
                exp_note = (m_active && !sfx_if.mute) ? note_tbl[m_evt][m_beat] : 0;
                exp_done = 1'b0;
                m_rise   = sfx_if.evt_trig & ~m_prev;
                m_prev   = sfx_if.evt_trig;
                m_winner = $clog2(int'(m_rise) + 1) - 1;
                if (m_winner >= 0 && (!m_active || m_winner >= int'(m_evt))) begin
                    m_active  = 1'b1;
                    m_evt     = 2'(m_winner);
                    m_elapsed = 0;
                end else if (m_active) begin
                    m_elapsed++;
                    if (m_elapsed == SEQ_CYC) begin
                        m_active  = 1'b0;
                        m_elapsed = 0;
                        exp_done  = 1'b1;
                    end
                end
                if (sfx_if.vol_up && !sfx_if.vol_down && exp_vol < VOL_MAX) exp_vol++;
                else if (sfx_if.vol_down && !sfx_if.vol_up && exp_vol > 0) exp_vol--;
            end
        end
    end

    logic [DIV_W+3:0] obs_seq, exp_seq;
    logic [7:0]       obs_vol, exp_vbus;

    assign obs_seq  = {sfx_if.note_div, sfx_if.playing, sfx_if.cur_evt, sfx_if.sfx_done};
    assign exp_seq  = {DIV_W'(exp_note), m_active, m_evt, exp_done};
    assign obs_vol  = {sfx_if.vol, sfx_if.led_vol};
    assign exp_vbus = {3'(exp_vol), 5'((1 << exp_vol) - 1)};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sfx_if.evt_trig = 4'b0001;
        tick(3);
        total++;
        if ({sfx_if.note_div, sfx_if.playing, sfx_if.cur_evt, sfx_if.sfx_done} !== {22'd0, 1'b0, 2'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got note=%0d playing=%0b evt=%0d done=%0b, expected all zero",
                     sfx_if.note_div, sfx_if.playing, sfx_if.cur_evt, sfx_if.sfx_done);
        end
        total++;
        if (obs_vol !== {3'd3, 5'b00111}) begin
            bad++;
            $display("[TB] FAIL reset_volume: got vol=%0d led=%b, expected vol=3 led=00111",
                     sfx_if.vol, sfx_if.led_vol);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            total++;
            if (sfx_if.playing !== 1'b0) begin
                bad++;
                $display("[TB] FAIL held_trigger_after_reset: got playing=%0b, expected 0", sfx_if.playing);
            end
        end
        sfx_if.evt_trig = 4'b0000;
        tick(1);
    endtask

    task automatic test_single();
        int dcnt = 0;
        int dat  = -1;
        sfx_if.evt_trig = 4'b0001;
        tick(1);
        total++;
        if ({sfx_if.playing, sfx_if.cur_evt, sfx_if.note_div} !== {1'b1, 2'd0, 22'd0}) begin
            bad++;
            $display("[TB] FAIL single_start: got playing=%0b evt=%0d note=%0d, expected 1 0 0",
                     sfx_if.playing, sfx_if.cur_evt, sfx_if.note_div);
        end
        tick(1);
        total++;
        if (sfx_if.note_div !== DIV_W'(note_tbl[0][0])) begin
            bad++;
            $display("[TB] FAIL single_first_note: got %0d, expected %0d", sfx_if.note_div, note_tbl[0][0]);
        end
        for (int k = 3; k <= SEQ_CYC + 3; k++) begin
            tick(1);
            total++;
            if (obs_seq !== exp_seq) begin
                bad++;
                $display("[TB] FAIL single_seq t=%0d: got %h, expected %h", k, obs_seq, exp_seq);
            end
            if (sfx_if.sfx_done === 1'b1) begin
                dcnt++;
                dat = k;
            end
        end
        total++;
        if (dcnt != 1 || dat != SEQ_CYC + 1) begin
            bad++;
            $display("[TB] FAIL single_done: got %0d pulses at t=%0d, expected 1 at t=%0d", dcnt, dat, SEQ_CYC + 1);
        end
        sfx_if.evt_trig = 4'b0000;
        tick(1);
    endtask

    task automatic test_preempt();
        int dcnt = 0;
        sfx_if.evt_trig = 4'b0001;
        tick(5);
        sfx_if.evt_trig = 4'b1001;
        tick(1);
        total++;
        if ({sfx_if.playing, sfx_if.cur_evt, sfx_if.sfx_done} !== {1'b1, 2'd3, 1'b0}) begin
            bad++;
            $display("[TB] FAIL preempt_load: got playing=%0b evt=%0d done=%0b, expected 1 3 0",
                     sfx_if.playing, sfx_if.cur_evt, sfx_if.sfx_done);
        end
        for (int k = 0; k < 25; k++) begin
            if (k == 5) sfx_if.evt_trig = 4'b1011;
            tick(1);
            total++;
            if (obs_seq !== exp_seq || sfx_if.cur_evt !== 2'd3) begin
                bad++;
                $display("[TB] FAIL preempt_seq k=%0d: got %h, expected %h", k, obs_seq, exp_seq);
            end
            if (sfx_if.sfx_done === 1'b1) dcnt++;
        end
        total++;
        if (dcnt != 1) begin
            bad++;
            $display("[TB] FAIL preempt_done_count: got %0d, expected 1", dcnt);
        end
        sfx_if.evt_trig = 4'b0000;
        tick(1);
    endtask

    task automatic test_simultaneous();
        sfx_if.evt_trig = 4'b0110;
        tick(1);
        total++;
        if (sfx_if.cur_evt !== 2'd2) begin
            bad++;
            $display("[TB] FAIL simultaneous_winner: got %0d, expected 2", sfx_if.cur_evt);
        end
        tick(6);
        sfx_if.evt_trig = 4'b0010;
        tick(1);
        sfx_if.evt_trig = 4'b0110;
        tick(1);
        for (int j = 1; j <= 19; j++) begin
            tick(1);
            total++;
            if (obs_seq !== exp_seq) begin
                bad++;
                $display("[TB] FAIL retrigger_seq j=%0d: got %h, expected %h", j, obs_seq, exp_seq);
            end
            if (j == 4 || j == 5) begin
                total++;
                if (sfx_if.note_div !== DIV_W'(note_tbl[2][j - 4])) begin
                    bad++;
                    $display("[TB] FAIL retrigger_note j=%0d: got %0d, expected %0d",
                             j, sfx_if.note_div, note_tbl[2][j - 4]);
                end
            end
        end
        sfx_if.evt_trig = 4'b0000;
        tick(1);
    endtask

    task automatic test_volume();
        for (int k = 0; k < 3; k++) begin
            sfx_if.vol_up = 1'b1;
            tick(1);
            sfx_if.vol_up = 1'b0;
            tick(1);
            total++;
            if (obs_vol !== exp_vbus) begin
                bad++;
                $display("[TB] FAIL vol_up k=%0d: got %h, expected %h", k, obs_vol, exp_vbus);
            end
        end
        total++;
        if (obs_vol !== {3'd5, 5'b11111}) begin
            bad++;
            $display("[TB] FAIL vol_saturate_top: got vol=%0d led=%b, expected 5 11111", sfx_if.vol, sfx_if.led_vol);
        end
        sfx_if.vol_up   = 1'b1;
        sfx_if.vol_down = 1'b1;
        tick(1);
        sfx_if.vol_up   = 1'b0;
        sfx_if.vol_down = 1'b0;
        tick(1);
        total++;
        if (sfx_if.vol !== 3'd5) begin
            bad++;
            $display("[TB] FAIL vol_both: got %0d, expected 5", sfx_if.vol);
        end
        for (int k = 0; k < 6; k++) begin
            sfx_if.vol_down = 1'b1;
            tick(1);
            sfx_if.vol_down = 1'b0;
            tick(1);
            total++;
            if (obs_vol !== exp_vbus) begin
                bad++;
                $display("[TB] FAIL vol_down k=%0d: got %h, expected %h", k, obs_vol, exp_vbus);
            end
        end
        total++;
        if (obs_vol !== 8'd0) begin
            bad++;
            $display("[TB] FAIL vol_saturate_bottom: got vol=%0d led=%b, expected 0 00000", sfx_if.vol, sfx_if.led_vol);
        end
    endtask

    task automatic test_mute_reset();
        int dat = -1;
        sfx_if.evt_trig = 4'b0001;
        tick(5);
        sfx_if.mute = 1'b1;
        tick(1);
        total++;
        if (sfx_if.note_div !== 22'd0 || sfx_if.playing !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mute_silence: got note=%0d playing=%0b, expected 0 1", sfx_if.note_div, sfx_if.playing);
        end
        for (int k = 7; k <= SEQ_CYC + 2; k++) begin
            tick(1);
            total++;
            if (obs_seq !== exp_seq) begin
                bad++;
                $display("[TB] FAIL mute_seq t=%0d: got %h, expected %h", k, obs_seq, exp_seq);
            end
            if (sfx_if.sfx_done === 1'b1) dat = k;
        end
        total++;
        if (dat != SEQ_CYC + 1) begin
            bad++;
            $display("[TB] FAIL mute_done_time: got t=%0d, expected t=%0d", dat, SEQ_CYC + 1);
        end
        sfx_if.mute     = 1'b0;
        sfx_if.evt_trig = 4'b0000;
        tick(1);
        sfx_if.evt_trig = 4'b0001;
        tick(9);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (sfx_if.playing !== 1'b0 || sfx_if.note_div !== 22'd0) begin
            bad++;
            $display("[TB] FAIL async_reset: got playing=%0b note=%0d, expected 0 0", sfx_if.playing, sfx_if.note_div);
        end
        tick(2);
        rst_n = 1'b1;
        tick(3);
        total++;
        if (sfx_if.playing !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_held_trigger: got playing=%0b, expected 0", sfx_if.playing);
        end
        sfx_if.evt_trig = 4'b0000;
        tick(1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            sfx_if.evt_trig = sfx_if.evt_trig ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            if ($urandom_range(15) == 0) sfx_if.mute = ~sfx_if.mute;
            sfx_if.vol_up   = ($urandom_range(5) == 0);
            sfx_if.vol_down = ($urandom_range(5) == 0);
            tick(1);
            total++;
            if (obs_seq !== exp_seq || obs_vol !== exp_vbus) begin
                bad++;
                $display("[TB] FAIL random k=%0d: got %h/%h, expected %h/%h", k, obs_seq, obs_vol, exp_seq, exp_vbus);
            end
        end
        sfx_if.evt_trig = 4'b0000;
        sfx_if.mute     = 1'b0;
        sfx_if.vol_up   = 1'b0;
        sfx_if.vol_down = 1'b0;
        tick(1);
    endtask

    initial begin
        sfx_if.evt_trig = 4'b0001;
        sfx_if.mute     = 1'b0;
        sfx_if.vol_up   = 1'b0;
        sfx_if.vol_down = 1'b0;
        test_reset();
        test_single();
        test_preempt();
        test_simultaneous();
        test_volume();
        test_mute_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
